// File: rtl/motor_ramp.sv
// motor_ramp: slew-limited duty sequencer for one motor channel, feeding a pwm
// generator and an H-bridge direction pin.
//
// Accepts signed speed commands and ramps the duty one LSB per prescaler tick.
// On a sign reversal it decelerates to zero, holds the bridge disabled for a
// dead time, then flips direction. It also handles a command watchdog and a
// level-sensitive emergency brake.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   cmd_valid  command strobe
//   cmd        signed two's-complement speed command (nbits+1 bits)
//   cmd_ready  command can be accepted (combinational, !brake)
//   brake      emergency stop, level-sensitive, highest priority
//   duty       duty value for pwm.in (registered)
//   dir        0 = forward, 1 = reverse (registered)
//   pwm_en     enable for pwm.en (registered)
//   at_target  duty/dir match the target, or target magnitude is 0 (registered)
//   timeout    watchdog expired; cleared by the next accepted command (registered)
module motor_ramp #(
    parameter int unsigned nbits       = 10,
    parameter int unsigned step_div    = 4800,
    parameter int unsigned dead_cycles = 48000,
    parameter int unsigned wdog_cycles = 4800000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [nbits:0]   cmd,
    output logic             cmd_ready,
    input  logic             brake,
    output logic [nbits-1:0] duty,
    output logic             dir,
    output logic             pwm_en,
    output logic             at_target,
    output logic             timeout
);

    // +1 keeps the widths non-zero when a parameter is 1.
    localparam int unsigned PW = $clog2(step_div + 1);
    localparam int unsigned DW = $clog2(dead_cycles + 1);
    localparam int unsigned WW = $clog2(wdog_cycles + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(step_div - 1);
    localparam logic [DW-1:0] DEAD_LOAD  = DW'(dead_cycles);
    localparam logic [WW-1:0] WDOG_MAX   = WW'(wdog_cycles);

    typedef enum logic [2:0] {StIdle, StRun, StDecel, StDead, StBrake} state_e;

    state_e           state_q, state_d;
    logic [nbits-1:0] duty_q, duty_d;
    logic             dir_q, dir_d;
    logic             pwm_en_q, pwm_en_d;
    logic             at_target_q, at_target_d;
    logic             timeout_q, timeout_d;
    logic [nbits-1:0] tgt_mag_q, tgt_mag_d;
    logic             tgt_sign_q, tgt_sign_d;
    logic [PW-1:0]    presc_q;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic [DW-1:0]    dead_q, dead_d;

    logic             accept;
    logic             tick;
    logic [nbits:0]   cmd_abs;
    logic [nbits-1:0] cmd_mag;

    assign cmd_ready = !brake;
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = (presc_q == PRESC_LAST);

    // |cmd| needs nbits+1 bits only for -2^nbits, which saturates to full scale.
    assign cmd_abs = cmd[nbits] ? (~cmd + {{nbits{1'b0}}, 1'b1}) : cmd;
    assign cmd_mag = cmd_abs[nbits] ? {nbits{1'b1}} : cmd_abs[nbits-1:0];

    // Target register and watchdog. An accepted command beats a same-edge expiry.
    always_comb begin
        tgt_mag_d  = tgt_mag_q;
        tgt_sign_d = tgt_sign_q;
        wdog_d     = wdog_q;
        timeout_d  = timeout_q;
        if (accept) begin
            tgt_mag_d  = cmd_mag;
            tgt_sign_d = cmd[nbits];
            wdog_d     = '0;
            timeout_d  = 1'b0;
        end else if (wdog_q != WDOG_MAX) begin
            wdog_d = wdog_q + 1'b1;
            if (wdog_q == WDOG_MAX - 1'b1) begin
                tgt_mag_d = '0;
                timeout_d = 1'b1;
            end
        end
    end

    // Sequencer. Decisions use the current target, so a tick coinciding with a
    // command still ramps toward the old target.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        if (brake) begin
            state_d = StBrake;
            duty_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    duty_d = '0;
                    if (tgt_mag_q != '0) begin
                        dir_d   = tgt_sign_q;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (tgt_mag_q != '0 && tgt_sign_q != dir_q) begin
                        state_d = StDecel;
                    end else if (duty_q == '0 && tgt_mag_q == '0) begin
                        state_d = StIdle;
                    end else if (tick) begin
                        if (duty_q < tgt_mag_q) begin
                            duty_d = duty_q + 1'b1;
                        end else if (duty_q > tgt_mag_q) begin
                            duty_d = duty_q - 1'b1;
                        end
                    end
                end
                StDecel: begin
                    if (tgt_mag_q != '0 && tgt_sign_q == dir_q) begin
                        state_d = StRun;
                    end else if (duty_q == '0) begin
                        state_d = StDead;
                        dead_d  = DEAD_LOAD;
                    end else if (tick) begin
                        duty_d = duty_q - 1'b1;
                    end
                end
                StDead: begin
                    // Target changes here only affect the exit, never the wait.
                    duty_d = '0;
                    if (dead_q == '0) begin
                        dir_d   = tgt_sign_q;
                        state_d = (tgt_mag_q != '0) ? StRun : StIdle;
                    end else begin
                        dead_d = dead_q - 1'b1;
                    end
                end
                StBrake: begin
                    // Only reached with brake low: release goes through dead time.
                    duty_d  = '0;
                    state_d = StDead;
                    dead_d  = DEAD_LOAD;
                end
                default: begin
                    state_d = StIdle;
                    duty_d  = '0;
                end
            endcase
        end
    end

    assign pwm_en_d    = (state_d == StRun) || (state_d == StDecel);
    assign at_target_d = (tgt_mag_d == '0) || (duty_d == tgt_mag_d && dir_d == tgt_sign_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            duty_q      <= '0;
            dir_q       <= 1'b0;
            pwm_en_q    <= 1'b0;
            at_target_q <= 1'b1;
            timeout_q   <= 1'b0;
            tgt_mag_q   <= '0;
            tgt_sign_q  <= 1'b0;
            presc_q     <= '0;
            wdog_q      <= '0;
            dead_q      <= '0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            pwm_en_q    <= pwm_en_d;
            at_target_q <= at_target_d;
            timeout_q   <= timeout_d;
            tgt_mag_q   <= tgt_mag_d;
            tgt_sign_q  <= tgt_sign_d;
            presc_q     <= tick ? '0 : presc_q + 1'b1;
            wdog_q      <= wdog_d;
            dead_q      <= dead_d;
        end
    end

    assign duty      = duty_q;
    assign dir       = dir_q;
    assign pwm_en    = pwm_en_q;
    assign at_target = at_target_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_motor_ramp.sv
// Testbench for motor_ramp with nbits=4, step_div=4, dead_cycles=8, wdog_cycles=200.
module tb_motor_ramp;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid = 1'b0;
    logic [NB:0]   cmd = '0;
    logic          cmd_ready;
    logic          brake = 1'b0;
    logic [NB-1:0] duty;
    logic          dir;
    logic          pwm_en;
    logic          at_target;
    logic          timeout;

    always #5 clk = ~clk;

    motor_ramp #(
        .nbits      (NB),
        .step_div   (4),
        .dead_cycles(8),
        .wdog_cycles(200)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd      (cmd),
        .cmd_ready(cmd_ready),
        .brake    (brake),
        .duty     (duty),
        .dir      (dir),
        .pwm_en   (pwm_en),
        .at_target(at_target),
        .timeout  (timeout)
    );

    typedef struct {
        string name;
        int    duty;
        int    dir;
        int    pwm_en;
        int    at_target;
        int    timeout;
    } exp_t;

    typedef struct {
        int cmd;
        int duty;
        int dir;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    int total = 0;
    int bad   = 0;

    int prev, last_c, d, zeros, dead_len, resume_dir, resume_duty, rises, first_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_cmd(input int v);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = v[NB:0];
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic push_exp(input string name, input int dt, input int dr);
        exp_t e;
        e.name      = name;
        e.duty      = dt;
        e.dir       = dr;
        e.pwm_en    = 1;
        e.at_target = 1;
        e.timeout   = 0;
        sb.push_back(e);
    endtask

    task automatic wait_target(input int limit);
        for (int i = 0; i < limit && at_target !== 1'b1; i++) @(negedge clk);
    endtask

    // Pops the oldest expectation once the DUT has settled and held.
    task automatic settle_and_compare();
        exp_t e;
        wait_target(400);
        repeat (10) @(negedge clk);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.name, "_duty"}, 32'(duty), e.duty);
            check({e.name, "_dir"}, 32'(dir), e.dir);
            check({e.name, "_pwm_en"}, 32'(pwm_en), e.pwm_en);
            check({e.name, "_at_target"}, 32'(at_target), e.at_target);
            check({e.name, "_timeout"}, 32'(timeout), e.timeout);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0] = '{-16, 15, 1};
        vecs[1] = '{4, 4, 0};
        vecs[2] = '{7, 7, 0};
        vecs[3] = '{2, 2, 0};
        vecs[4] = '{-1, 1, 1};
        vecs[5] = '{15, 15, 0};
        vecs[6] = '{-9, 9, 1};

        // Reset state
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_duty", 32'(duty), 0);
        check("rst_dir", 32'(dir), 0);
        check("rst_pwm_en", 32'(pwm_en), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_at_target", 32'(at_target), 1);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        rst = 1'b0;

        // Ramp up to +5: unit steps, exactly step_div cycles apart
        send_cmd(5);
        prev   = 0;
        last_c = -1;
        for (int c = 0; c < 100; c++) begin
            if (int'(duty) != prev) begin
                d = int'(duty) - prev;
                check("ramp_step", d, 1);
                if (last_c >= 0) check("ramp_spacing", c - last_c, 4);
                last_c = c;
                prev   = int'(duty);
            end
            if (duty == 4'd5) break;
            @(negedge clk);
        end
        check("ramp_final_duty", 32'(duty), 5);
        check("ramp_dir", 32'(dir), 0);
        check("ramp_pwm_en", 32'(pwm_en), 1);
        check("ramp_at_target", 32'(at_target), 1);
        check("ramp_timeout", 32'(timeout), 0);

        // Reversal to -3: decel, 9 disabled cycles, flip, ramp to 3
        send_cmd(-3);
        zeros       = 0;
        dead_len    = -1;
        resume_dir  = -1;
        resume_duty = -1;
        rises       = 0;
        prev        = 5;
        for (int c = 0; c < 300; c++) begin
            if (pwm_en === 1'b0) begin
                zeros++;
            end else if (zeros > 0 && dead_len < 0) begin
                dead_len    = zeros;
                resume_dir  = int'(dir);
                resume_duty = int'(duty);
            end
            if (dead_len < 0 && int'(duty) > prev) rises++;
            prev = int'(duty);
            if (dead_len >= 0 && at_target === 1'b1) break;
            @(negedge clk);
        end
        check("rev_dead_len", dead_len, 9);
        check("rev_resume_dir", resume_dir, 1);
        check("rev_resume_duty", resume_duty, 0);
        check("rev_no_rise_in_decel", rises, 0);
        check("rev_final_duty", 32'(duty), 3);
        check("rev_final_dir", 32'(dir), 1);

        // Table-driven commands, including saturation of -16
        for (int i = 0; i < 7; i++) begin
            push_exp($sformatf("vec%0d", i), vecs[i].duty, vecs[i].dir);
            send_cmd(vecs[i].cmd);
            settle_and_compare();
        end

        // Watchdog: +4, then silence for 200 cycles
        send_cmd(4);
        first_to = -1;
        for (int c = 0; c < 260; c++) begin
            if (timeout === 1'b1) begin
                first_to = c;
                break;
            end
            @(negedge clk);
        end
        check("wdog_expiry_cycle", first_to, 200);
        check("wdog_duty_at_expiry", 32'(duty), 4);
        for (int i = 0; i < 100 && pwm_en !== 1'b0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("wdog_idle_duty", 32'(duty), 0);
        check("wdog_idle_pwm_en", 32'(pwm_en), 0);
        check("wdog_timeout_held", 32'(timeout), 1);
        check("wdog_at_target", 32'(at_target), 1);
        push_exp("wdog_recover", 2, 0);
        send_cmd(2);
        check("wdog_clear", 32'(timeout), 0);
        settle_and_compare();

        // Brake at duty 7: immediate stop, commands ignored, dead time on release
        send_cmd(7);
        wait_target(200);
        check("brake_pre_duty", 32'(duty), 7);
        @(negedge clk);
        brake     = 1'b1;
        cmd_valid = 1'b1;
        cmd       = 5'b11011;
        #1;
        check("brake_cmd_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        check("brake_duty", 32'(duty), 0);
        check("brake_pwm_en", 32'(pwm_en), 0);
        repeat (19) @(negedge clk);
        brake     = 1'b0;
        cmd_valid = 1'b0;
        zeros     = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (pwm_en === 1'b0) zeros++;
            else break;
        end
        check("brake_dead_len", zeros, 9);
        check("brake_resume_dir", 32'(dir), 0);
        push_exp("brake_recover", 7, 0);
        settle_and_compare();

        // Async reset while decelerating in reverse
        send_cmd(-6);
        wait_target(200);
        check("pre_rst_dir", 32'(dir), 1);
        send_cmd(5);
        for (int i = 0; i < 100 && !(pwm_en === 1'b1 && duty <= 4'd3); i++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_duty", 32'(duty), 0);
        check("arst_dir", 32'(dir), 0);
        check("arst_pwm_en", 32'(pwm_en), 0);
        check("arst_timeout", 32'(timeout), 0);
        check("arst_at_target", 32'(at_target), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_pwm_en", 32'(pwm_en), 0);
        check("post_rst_duty", 32'(duty), 0);
        check("post_rst_dir", 32'(dir), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motor_ramp.md
# motor_ramp

Closed sequencer in front of the `pwm` generator for one motor channel. It accepts signed speed commands and ramps the PWM duty toward each target at a fixed slew rate. On a sign reversal it decelerates to zero, holds a dead time with the bridge disabled, then flips direction. It also enforces a command watchdog and an emergency brake. Its `duty`, `pwm_en` and `dir` outputs drive the `pwm` instance's `in` and `en` ports and the H-bridge direction pin.

## Interface
- `nbits`, 10: duty width; must match the downstream `pwm`.
- `step_div`, 4800: clock cycles per ramp tick; one duty LSB changes per tick. Must be ≥ 1.
- `dead_cycles`, 48000: clock cycles the bridge stays disabled before a direction flip. Must be ≥ 1.
- `wdog_cycles`, 4800000: clock cycles without an accepted command before the target is forced to 0.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command strobe.
- `cmd`  in  nbits+1  signed two's-complement speed command.
- `cmd_ready`  out  1  command can be accepted; equals `!brake` (combinational).
- `brake`  in  1  level-sensitive emergency stop.
- `duty`  out  nbits  duty value for `pwm.in`.
- `dir`  out  1  0 = forward, 1 = reverse.
- `pwm_en`  out  1  enable for `pwm.en`.
- `at_target`  out  1  `duty` equals the target magnitude and `dir` equals the target sign (or the target magnitude is 0).
- `timeout`  out  1  watchdog expired; cleared by the next accepted command.

## Operation
- **Accept:** a command is accepted when `cmd_valid && cmd_ready`.
  - Target sign = `cmd` MSB.
  - Target magnitude = |cmd|, saturated to 2^nbits−1. The case −2^nbits saturates to 2^nbits−1 reverse.
  - Acceptance reloads the watchdog and clears `timeout`.
- **Watchdog:** counts clock cycles since the last accepted command. When it reaches `wdog_cycles`, the target magnitude is set to 0 and `timeout` is set. The count then holds.
- **Ramp tick:** a free-running prescaler counts 0..step_div−1 and produces a one-cycle tick on wrap. It is cleared only by `rst`.
- **States:**
  - **IDLE**
    - `pwm_en`=0, `duty`=0.
    - If target magnitude ≠ 0: `dir`←target sign, go to RUN.
  - **RUN**
    - `pwm_en`=1.
    - If target magnitude ≠ 0 and target sign ≠ `dir`, go to DECEL (same cycle decision).
    - Otherwise, on each tick: `duty`+1 if `duty` < magnitude, `duty`−1 if `duty` > magnitude.
    - If `duty`=0 and target magnitude=0, go to IDLE.
  - **DECEL**
    - `pwm_en`=1.
    - On each tick: `duty`−1.
    - When `duty`=0: go to DEAD and load the dead counter with `dead_cycles`.
    - A new command restoring the original sign while in DECEL returns to RUN.
  - **DEAD**
    - `pwm_en`=0, `duty`=0.
    - Counter decrements each cycle.
    - At 0: `dir`←target sign; go to RUN if target magnitude ≠ 0, else IDLE.
    - Target changes during DEAD are absorbed; the wait is not restarted.
  - **BRAKE**
    - Entered from any state while `brake`=1: `duty`←0 and `pwm_en`←0 at the next edge.
    - On `brake` falling: load the dead counter and go to DEAD.
- **Brake and commands:** `brake` has priority over everything. Commands are not accepted while braking, but the watchdog keeps counting.

## Timing
- **Reset values:** state IDLE, `duty`=0, `dir`=0, `pwm_en`=0, `timeout`=0, target=0, prescaler=0, watchdog=0. `cmd_ready`=1 whenever `brake`=0.
- **Registered outputs:** all outputs except `cmd_ready` are registered.
- **Command latency:** a command accepted at edge k is visible in the target at k+1. The first `duty` change happens on the first tick strictly after k.
- **IDLE→RUN:** one cycle after the target update. `pwm_en` rises in that cycle, and `duty` steps at the next tick.
- **Full ramp time:** 0→M takes M ticks, i.e. M·step_div cycles ±step_div.
- **Dead time:** `pwm_en`=0 for exactly `dead_cycles`+1 cycles, from DEAD entry through the first RUN cycle exclusive.
- **Simultaneous events:** if a tick and a command arrive on the same edge, the tick uses the old target. If the watchdog expiry and an accepted command land on the same edge, the command wins.
- **Reset mid-operation:** reset returns to the reset values immediately (asynchronous). The pwm sees `en`=0 at once.

## Test plan
Bench parameters for all scenarios: nbits=4, step_div=4, dead_cycles=8, wdog_cycles=200.

1. **Ramp up:** reset, then cmd=+5 → `pwm_en`=1, `dir`=0, `duty` steps 1..5 every 4 cycles, `at_target`=1 at `duty`=5, `timeout`=0.
2. **Reversal:** at `duty`=5 fwd, send cmd=−3 → `duty` falls 5→0, `pwm_en`=0 for 9 cycles, then `dir`=1, `duty` rises to 3.
3. **Saturation:** cmd=−16 → target magnitude 15, reverse; `duty` reaches 15 and holds.
4. **Watchdog:** cmd=+4, then no commands for 200 cycles → `timeout`=1, `duty` ramps to 0, state IDLE, `pwm_en`=0. Then cmd=+2 → `timeout`=0, ramp to 2.
5. **Brake:** at `duty`=7, assert `brake` for 20 cycles → next edge `duty`=0, `pwm_en`=0, `cmd_ready`=0, `cmd_valid` ignored. On release: 9-cycle dead time, then ramp back to 7.
6. **Async reset:** assert `rst` mid-DECEL → all outputs go to reset values without a clock edge. After release, IDLE with `dir`=0.
